// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes each sampled WIDTH-bit Johnson code to its
// binary index and checks it against the expected successor. Reports the
// lock state, one-cycle error pulses and a saturating error count.
module johnson_decoder #(
   parameter int WIDTH    = 4,
   parameter int IDX_W    = 3,
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] jc_in,
   input  logic             err_clr,
   output logic [IDX_W-1:0] idx,
   output logic             idx_valid,
   output logic             locked,
   output logic             illegal,
   output logic             seq_err,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int SEQ_LEN = 2 * WIDTH;
   localparam int RUN_W   = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

   typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [RUN_W-1:0] run, run_nxt;
   logic             code_legal;
   logic [IDX_W-1:0] code_idx;
   logic             ill_nxt, seq_chk, hit, seq_nxt;

   // A Johnson code has at most one boundary between its run of ones and zeros.
   function automatic logic is_legal(input logic [WIDTH-1:0] jc);
      int changes;
      changes = 0;
      for (int i = 0; i < WIDTH - 1; i++) begin
         if (jc[i] != jc[i+1]) changes++;
      end
      return (changes <= 1);
   endfunction

   // Filling half counts ones upward; emptying half counts down from SEQ_LEN.
   function automatic logic [IDX_W-1:0] decode(input logic [WIDTH-1:0] jc);
      int ones;
      ones = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (jc[i]) ones++;
      end
      if (jc[WIDTH-1]) return IDX_W'(SEQ_LEN - ones);
      else             return IDX_W'(ones);
   endfunction

   function automatic logic [IDX_W-1:0] succ(input logic [IDX_W-1:0] cur);
      if (int'(cur) >= SEQ_LEN - 1) return '0;
      else                          return cur + 1'b1;
   endfunction

   function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + 1'b1;
   endfunction

   function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] cnt);
      return (cnt >= RUN_W'(LOCK_CNT)) ? cnt : cnt + 1'b1;
   endfunction

   // Classify the current sample: illegal, expected successor, or sequence break.
   always_comb begin
      code_legal = is_legal(jc_in);
      code_idx   = decode(jc_in);
      ill_nxt    = en & ~code_legal;
      seq_chk    = en & code_legal & idx_valid;
      hit        = seq_chk & (code_idx == succ(idx));
      seq_nxt    = seq_chk & ~hit;
   end

   // Run of consecutive correct transitions; any sample that is not a hit restarts it.
   always_comb begin
      run_nxt = run;
      if (en) begin
         if (hit) run_nxt = sat_inc_run(run);
         else     run_nxt = '0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state <= SEARCH;
      else      state <= state_nxt;
   end

   // FSM next state: lock when the run reaches LOCK_CNT, drop on any error.
   always_comb begin
      state_nxt = state;
      if (ill_nxt || seq_nxt)
         state_nxt = SEARCH;
      else if (state == SEARCH && hit && run_nxt == RUN_W'(LOCK_CNT))
         state_nxt = LOCKED;
   end

   // FSM output.
   always_comb begin
      locked = (state == LOCKED);
   end

   // Decoded index, validity, run counter and error pulses.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         idx       <= '0;
         idx_valid <= 1'b0;
         run       <= '0;
         illegal   <= 1'b0;
         seq_err   <= 1'b0;
      end else begin
         if (en && code_legal) idx <= code_idx;
         if (en)               idx_valid <= code_legal;
         run     <= run_nxt;
         illegal <= ill_nxt;
         seq_err <= seq_nxt;
      end
   end

   // Saturating error counter; err_clr wins over a simultaneous error.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)                    err_cnt <= '0;
      else if (err_clr)            err_cnt <= '0;
      else if (ill_nxt || seq_nxt) err_cnt <= sat_inc_err(err_cnt);
   end

endmodule

// File: tb/tb_johnson_decoder.sv
// Bench for johnson_decoder: directed vector table, hand-written corner
// sequences (error-counter saturation, asynchronous clear) and a randomized
// run compared against a table-lookup reference model.
module tb_johnson_decoder;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       en = 1'b0;
   logic [3:0] jc_in = 4'b0000;
   logic       err_clr = 1'b0;

   logic [2:0] a_idx, b_idx;
   logic       a_vld, a_lck, a_ill, a_seq;
   logic       b_vld, b_lck, b_ill, b_seq;
   logic [7:0] a_err;
   logic [1:0] b_err;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   johnson_decoder #(.WIDTH(4), .IDX_W(3), .LOCK_CNT(3), .ERR_W(8)) dut_a (
      .clk(clk), .clr(clr), .en(en), .jc_in(jc_in), .err_clr(err_clr),
      .idx(a_idx), .idx_valid(a_vld), .locked(a_lck), .illegal(a_ill),
      .seq_err(a_seq), .err_cnt(a_err));

   johnson_decoder #(.WIDTH(4), .IDX_W(3), .LOCK_CNT(3), .ERR_W(2)) dut_b (
      .clk(clk), .clr(clr), .en(en), .jc_in(jc_in), .err_clr(err_clr),
      .idx(b_idx), .idx_valid(b_vld), .locked(b_lck), .illegal(b_ill),
      .seq_err(b_seq), .err_cnt(b_err));

   typedef struct {
      logic       en;
      logic [3:0] code;
      logic       eclr;
      logic [2:0] idx;
      logic       vld;
      logic       lck;
      logic       ill;
      logic       seq;
      logic [7:0] err;
   } vec_t;

   vec_t vecs[$];

   // reference model state
   logic [3:0] codes[8];
   int m_idx, m_run, m_err8, m_err2;
   bit m_vld, m_lck, m_ill, m_seq;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(input logic e, input logic [3:0] c, input logic ec);
      @(negedge clk);
      en = e; jc_in = c; err_clr = ec;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic e, input logic [3:0] c, input logic ec,
                      input int i, input logic v, input logic l,
                      input logic il, input logic sq, input int er);
      vec_t r;
      r.en = e; r.code = c; r.eclr = ec; r.idx = 3'(i); r.vld = v;
      r.lck = l; r.ill = il; r.seq = sq; r.err = 8'(er);
      vecs.push_back(r);
   endtask

   function automatic int lookup(input logic [3:0] c);
      for (int k = 0; k < 8; k++) if (codes[k] == c) return k;
      return -1;
   endfunction

   task automatic model_reset();
      m_idx = 0; m_run = 0; m_err8 = 0; m_err2 = 0;
      m_vld = 0; m_lck = 0; m_ill = 0; m_seq = 0;
   endtask

   task automatic model_step(input bit e, input logic [3:0] c, input bit ec);
      int k;
      m_ill = 0; m_seq = 0;
      if (e) begin
         k = lookup(c);
         if (k < 0) begin
            m_ill = 1; m_vld = 0; m_run = 0; m_lck = 0;
         end else if (!m_vld) begin
            m_idx = k; m_vld = 1; m_run = 0;
         end else if (k == (m_idx + 1) % 8) begin
            m_run = (m_run < 3) ? m_run + 1 : 3;
            if (m_run == 3) m_lck = 1;
            m_idx = k;
         end else begin
            m_seq = 1; m_run = 0; m_lck = 0; m_idx = k;
         end
      end
      if (ec) begin
         m_err8 = 0; m_err2 = 0;
      end else if (m_ill || m_seq) begin
         m_err8 = (m_err8 < 255) ? m_err8 + 1 : 255;
         m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
      end
   endtask

   task automatic check_model();
      chk("rnd_a_idx", int'(a_idx), m_idx);
      chk("rnd_a_vld", int'(a_vld), int'(m_vld));
      chk("rnd_a_lck", int'(a_lck), int'(m_lck));
      chk("rnd_a_ill", int'(a_ill), int'(m_ill));
      chk("rnd_a_seq", int'(a_seq), int'(m_seq));
      chk("rnd_a_err", int'(a_err), m_err8);
      chk("rnd_b_idx", int'(b_idx), m_idx);
      chk("rnd_b_lck", int'(b_lck), int'(m_lck));
      chk("rnd_b_err", int'(b_err), m_err2);
   endtask

   initial begin
      logic [3:0] c;
      int gen_k, r;
      bit e, ec;

      // Legal code table built from the successor rule starting at all-zeros.
      c = 4'b0000;
      for (int k = 0; k < 8; k++) begin
         codes[k] = c;
         c = {c[2:0], ~c[3]};
      end

      // Directed vectors: en, code, err_clr | idx, valid, locked, illegal, seq_err, err_cnt
      add(1, 4'b0000, 0, 0, 1, 0, 0, 0, 0);
      add(1, 4'b0001, 0, 1, 1, 0, 0, 0, 0);
      add(1, 4'b0011, 0, 2, 1, 0, 0, 0, 0);
      add(1, 4'b0111, 0, 3, 1, 1, 0, 0, 0);
      add(1, 4'b1111, 0, 4, 1, 1, 0, 0, 0);
      add(1, 4'b1110, 0, 5, 1, 1, 0, 0, 0);
      add(1, 4'b1100, 0, 6, 1, 1, 0, 0, 0);
      add(1, 4'b1000, 0, 7, 1, 1, 0, 0, 0);
      add(1, 4'b0101, 0, 7, 0, 0, 1, 0, 1);
      add(1, 4'b0011, 0, 2, 1, 0, 0, 0, 1);
      add(1, 4'b0111, 0, 3, 1, 0, 0, 0, 1);
      add(1, 4'b1111, 0, 4, 1, 0, 0, 0, 1);
      add(1, 4'b1110, 0, 5, 1, 1, 0, 0, 1);
      add(1, 4'b1100, 0, 6, 1, 1, 0, 0, 1);
      add(1, 4'b1000, 0, 7, 1, 1, 0, 0, 1);
      for (int i = 0; i < 5; i++) add(0, 4'b0101, 0, 7, 1, 1, 0, 0, 1);
      add(1, 4'b0000, 0, 0, 1, 1, 0, 0, 1);
      add(1, 4'b0001, 0, 1, 1, 1, 0, 0, 1);
      add(1, 4'b0111, 0, 3, 1, 0, 0, 1, 2);
      add(1, 4'b0111, 0, 3, 1, 0, 0, 1, 3);
      add(0, 4'b0000, 1, 3, 1, 0, 0, 0, 0);

      clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_idx", int'(a_idx), 0);
      chk("rst_vld", int'(a_vld), 0);
      chk("rst_lck", int'(a_lck), 0);
      chk("rst_ill", int'(a_ill), 0);
      chk("rst_seq", int'(a_seq), 0);
      chk("rst_err", int'(a_err), 0);
      @(negedge clk);
      clr = 1'b1;

      foreach (vecs[n]) begin
         apply(vecs[n].en, vecs[n].code, vecs[n].eclr);
         chk($sformatf("v%0d_idx", n), int'(a_idx), int'(vecs[n].idx));
         chk($sformatf("v%0d_vld", n), int'(a_vld), int'(vecs[n].vld));
         chk($sformatf("v%0d_lck", n), int'(a_lck), int'(vecs[n].lck));
         chk($sformatf("v%0d_ill", n), int'(a_ill), int'(vecs[n].ill));
         chk($sformatf("v%0d_seq", n), int'(a_seq), int'(vecs[n].seq));
         chk($sformatf("v%0d_err", n), int'(a_err), int'(vecs[n].err));
      end

      // Saturation of a 2-bit error counter, then err_clr against a simultaneous error.
      for (int i = 0; i < 5; i++) begin
         apply(1, 4'b0101, 0);
         chk("sat_b_ill", int'(b_ill), 1);
         chk("sat_b_err", int'(b_err), (i + 1 < 3) ? i + 1 : 3);
         chk("sat_a_err", int'(a_err), i + 1);
      end
      apply(1, 4'b1010, 1);
      chk("eclr_b_ill", int'(b_ill), 1);
      chk("eclr_b_err", int'(b_err), 0);
      chk("eclr_a_err", int'(a_err), 0);

      // Asynchronous clear between edges while locked.
      apply(1, 4'b0000, 0);
      apply(1, 4'b0001, 0);
      apply(1, 4'b0011, 0);
      apply(1, 4'b0111, 0);
      chk("pre_clr_lck", int'(a_lck), 1);
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #3 clr = 1'b0;
      #1;
      chk("aclr_idx", int'(a_idx), 0);
      chk("aclr_vld", int'(a_vld), 0);
      chk("aclr_lck", int'(a_lck), 0);
      chk("aclr_ill", int'(a_ill), 0);
      chk("aclr_seq", int'(a_seq), 0);
      chk("aclr_err", int'(a_err), 0);
      #2 clr = 1'b1;
      apply(1, 4'b0011, 0);
      chk("post_idx", int'(a_idx), 2);
      chk("post_vld", int'(a_vld), 1);
      chk("post_seq", int'(a_seq), 0);
      apply(1, 4'b0111, 0);
      chk("post2_idx", int'(a_idx), 3);
      chk("post2_seq", int'(a_seq), 0);

      // Randomized run against the reference model.
      @(negedge clk);
      en = 1'b0; err_clr = 1'b0;
      clr = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      model_reset();
      gen_k = 0;
      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 99));
         e = 1; ec = ($urandom_range(0, 99) < 2);
         if (r < 8) begin
            c = 4'b0101;
            for (int t = 0; t < 100; t++) begin
               c = 4'($urandom_range(0, 15));
               if (lookup(c) < 0) break;
            end
            if (lookup(c) >= 0) c = 4'b0101;
         end else if (r < 14) begin
            gen_k = int'($urandom_range(0, 7));
            c = codes[gen_k];
         end else if (r < 20) begin
            e = 0;
            c = 4'($urandom_range(0, 15));
         end else begin
            gen_k = (gen_k + 1) % 8;
            c = codes[gen_k];
         end
         apply(e, c, ec);
         model_step(e, c, ec);
         check_model();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
